// File: rtl/bsearch_pkg.sv
// Shared types and helpers for the binary-search engine.
package bsearch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PROBE,
      COMPARE,
      DONE
   } bs_state_e;

   // Holds lo + hi without overflow and the signed -1 of an exhausted upper bound.
   function automatic int unsigned mid_width(input int unsigned addr_w);
      return addr_w + 2;
   endfunction

endpackage

// File: rtl/bsearch_ram.sv
// Single-port-write, single-port-read memory with a registered read address (1-cycle latency).
module bsearch_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0] rd_addr_q;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_addr_q <= rd_addr;
   end

   assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/bsearch_engine.sv
// Binary search over a sorted internal memory with a start/done handshake.
// Define BSEARCH_LOWER_BOUND_EN to add the lb_loc lower-bound output.
module bsearch_engine
   import bsearch_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] key,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W-1:0] loc
`ifdef BSEARCH_LOWER_BOUND_EN
   ,
   output logic [ADDR_W:0]   lb_loc
`endif
);

   localparam int unsigned MW = mid_width(ADDR_W);
   localparam logic [ADDR_W:0] HI_INIT = {1'b0, {ADDR_W{1'b1}}};

   bs_state_e         state_q, state_d;
   logic [ADDR_W:0]   lo_q, lo_d;
   logic [ADDR_W:0]   hi_q, hi_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic              found_q, found_d;
   logic [ADDR_W-1:0] loc_q, loc_d;

   logic [MW-1:0]     mid_w;
   logic [MW-1:0]     lo_n;
   logic [MW-1:0]     hi_n;
   logic [DATA_W-1:0] rd_data;
   logic              ram_we;
   logic              accept;
   logic              hit;

   // Bounds are non-negative whenever a probe is issued, so zero-extension is safe here.
   assign mid_w = (MW'(lo_q) + MW'(hi_q)) >> 1;

   // Candidate bounds after this compare, widened so DEPTH and -1 both compare correctly.
   assign hit  = (rd_data == key_q);
   assign lo_n = (rd_data < key_q) ? (mid_w + MW'(1)) : MW'(lo_q);
   assign hi_n = (rd_data > key_q) ? (mid_w - MW'(1)) : {hi_q[ADDR_W], hi_q};

   assign ram_we = wr_en && ((state_q == IDLE) || (state_q == DONE));
   assign accept = (state_q == IDLE) && start;

   bsearch_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clock   (clock),
      .wr_en   (ram_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (mid_w[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      key_d   = key_q;
      found_d = found_q;
      loc_d   = loc_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key;
               lo_d    = '0;
               hi_d    = HI_INIT;
               found_d = 1'b0;
               loc_d   = '0;
               state_d = PROBE;
            end
         end
         PROBE: begin
            state_d = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               found_d = 1'b1;
               loc_d   = mid_w[ADDR_W-1:0];
               state_d = DONE;
            end else begin
               lo_d = lo_n[ADDR_W:0];
               hi_d = hi_n[ADDR_W:0];
               if ($signed(lo_n) > $signed(hi_n)) begin
                  found_d = 1'b0;
                  state_d = DONE;
               end else begin
                  state_d = PROBE;
               end
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         key_q   <= '0;
         found_q <= 1'b0;
         loc_q   <= '0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         key_q   <= key_d;
         found_q <= found_d;
         loc_q   <= loc_d;
      end
   end

`ifdef BSEARCH_LOWER_BOUND_EN
   logic [ADDR_W:0] lb_q;

   // On a miss the final lo is the insertion point; on a hit it is the match itself.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lb_q <= '0;
      end else if (accept) begin
         lb_q <= '0;
      end else if ((state_q == COMPARE) && (state_d == DONE)) begin
         lb_q <= hit ? {1'b0, mid_w[ADDR_W-1:0]} : lo_n[ADDR_W:0];
      end
   end

   assign lb_loc = lb_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

   assign busy  = (state_q == PROBE) || (state_q == COMPARE);
   assign done  = (state_q == DONE);
   assign found = found_q;
   assign loc   = loc_q;

endmodule

// File: tb/tb_bsearch_engine.sv
// Randomized self-checking bench for bsearch_engine against an array-based reference.
module tb_bsearch_engine;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 5;
   localparam int DEPTH = 32;

   logic              clock;
   logic              reset_n;
   logic              start;
   logic [DATA_W-1:0] key;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              found;
   logic [ADDR_W-1:0] loc;
`ifdef BSEARCH_LOWER_BOUND_EN
   logic [ADDR_W:0]   lb_loc;
`endif

   logic [DATA_W-1:0] mem_m [DEPTH];
   int n_checks;
   int n_pass;

   bsearch_engine #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .key     (key),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .found   (found),
      .loc     (loc)
`ifdef BSEARCH_LOWER_BOUND_EN
      ,
      .lb_loc  (lb_loc)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_word(input int a, input logic [DATA_W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      mem_m[a] = d;
   endtask

   // Reference: linear scan for hit/lower bound, textbook search for the probe count.
   task automatic ref_search(input logic [DATA_W-1:0] k, output bit f, output int idx,
                             output int lb, output int probes);
      int lo;
      int hi;
      int mid;
      bit hit;
      f = 0;
      idx = 0;
      lb = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_m[i] == k && !f) begin
            f = 1;
            idx = i;
         end
         if (mem_m[i] < k) lb++;
      end
      if (f) lb = idx;
      lo = 0;
      hi = DEPTH - 1;
      probes = 0;
      hit = 0;
      while (lo <= hi && !hit) begin
         mid = (lo + hi) / 2;
         probes++;
         if (mem_m[mid] == k) hit = 1;
         else if (mem_m[mid] < k) lo = mid + 1;
         else hi = mid - 1;
      end
   endtask

   // wr_start: write together with start; wr_mid: write attempt while busy (must be ignored).
   task automatic run_search(input logic [DATA_W-1:0] k, input bit wr_start, input bit wr_mid,
                             input int wa, input logic [DATA_W-1:0] wd);
      bit f;
      int idx;
      int lb;
      int probes;
      int cyc;
      bit busy_ok;
      if (wr_start) begin
         wr_en   = 1'b1;
         wr_addr = ADDR_W'(wa);
         wr_data = wd;
         mem_m[wa] = wd;
      end
      ref_search(k, f, idx, lb, probes);
      key   = k;
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      cyc = 1;
      busy_ok = 1;
      while (!done && cyc < 40) begin
         if (!busy) busy_ok = 0;
         if (wr_mid && cyc == 2) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(wa);
            wr_data = wd;
         end else begin
            wr_en = 1'b0;
         end
         tick();
         cyc++;
      end
      wr_en = 1'b0;
      check($sformatf("latency k=%0d", k), cyc, 1 + 2 * probes);
      check($sformatf("busy_run k=%0d", k), {31'd0, busy_ok}, 1);
      check($sformatf("busy_done k=%0d", k), {31'd0, busy}, 0);
      check($sformatf("found k=%0d", k), {31'd0, found}, {31'd0, f});
      if (f) check($sformatf("loc k=%0d", k), {27'd0, loc}, idx);
`ifdef BSEARCH_LOWER_BOUND_EN
      check($sformatf("lb_loc k=%0d", k), {26'd0, lb_loc}, lb);
`endif
      tick();
      check($sformatf("idle k=%0d", k), {31'd0, done}, 0);
      check($sformatf("held found k=%0d", k), {31'd0, found}, {31'd0, f});
   endtask

   initial begin
      int v;
      int cyc;
      bit hold_ok;
      logic [DATA_W-1:0] k;
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      key      = '0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      tick();
      tick();
      check("rst busy", {31'd0, busy}, 0);
      check("rst done", {31'd0, done}, 0);
      check("rst found", {31'd0, found}, 0);
      check("rst loc", {27'd0, loc}, 0);
`ifdef BSEARCH_LOWER_BOUND_EN
      check("rst lb_loc", {26'd0, lb_loc}, 0);
`endif
      reset_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) load_word(i, DATA_W'(2 * i));

      run_search(8'd30, 0, 0, 0, 0);
      run_search(8'd40, 0, 0, 0, 0);
      run_search(8'd41, 0, 0, 0, 0);
      run_search(8'd255, 0, 0, 0, 0);
      run_search(8'd0, 0, 0, 0, 0);

      // Held start: done must persist and no new search may begin.
      key   = 8'd30;
      start = 1'b1;
      tick();
      key = 8'd0;
      cyc = 1;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
      check("hold latency", cyc, 3);
      hold_ok = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!done || busy || !found || loc != 5'd15) hold_ok = 0;
      end
      check("hold done", {31'd0, hold_ok}, 1);
      start = 1'b0;
      tick();
      check("hold release done", {31'd0, done}, 0);
      check("hold release loc", {27'd0, loc}, 15);

      // Write while busy is ignored; write together with start is seen by the first probe.
      run_search(8'd40, 0, 1, 20, 8'd99);
      run_search(8'd40, 1, 0, 20, 8'd99);
      load_word(20, 8'd40);

      // Reset mid-search aborts, keeps memory.
      key   = 8'd40;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      check("abort busy", {31'd0, busy}, 0);
      check("abort done", {31'd0, done}, 0);
      check("abort found", {31'd0, found}, 0);
      check("abort loc", {27'd0, loc}, 0);
      reset_n = 1'b1;
      run_search(8'd30, 0, 0, 0, 0);

      // Random sorted contents with strictly increasing values.
      for (int r = 0; r < 4; r++) begin
         v = $urandom_range(0, 5);
         for (int i = 0; i < DEPTH; i++) begin
            v = v + $urandom_range(1, 7);
            load_word(i, DATA_W'(v));
         end
         for (int j = 0; j < 8; j++) begin
            if ($urandom_range(0, 1) == 1) k = mem_m[$urandom_range(0, DEPTH - 1)];
            else k = DATA_W'($urandom_range(0, 255));
            run_search(k, 0, 0, 0, 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bsearch_engine.md
# bsearch_engine

Parametrised binary-search engine over an internal sorted, synchronously-read memory of `DEPTH = 2**ADDR_W` words of `DATA_W` bits. It is the next generation of the lab 4 fixed 32×8 search:
- data width and depth are parameters;
- the memory has a load port;
- the start/done handshake is explicit;
- lower-bound reporting is optional.

It sits under the board top level. Switches and keys drive `key` and `start`, and `loc`/`found` feed the seven-segment decoders.

## Interface
Parameters:
- `DATA_W`, 8, word and key width (unsigned)
- `ADDR_W`, 5, address width; `DEPTH = 2**ADDR_W`

Ports:
- `clock`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  level request; accepted in IDLE
- `key`  in  DATA_W  search key, latched on accept
- `wr_en`  in  1  memory write strobe
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `busy`  out  1  high in PROBE/COMPARE
- `done`  out  1  high in DONE
- `found`  out  1  exact match found, valid while `done`
- `loc`  out  ADDR_W  match index, valid while `done && found`
- `lb_loc`  out  ADDR_W+1  only with `BSEARCH_LOWER_BOUND_EN`; see Configuration

## Operation
- Memory contents must be ascending unsigned. With unsorted contents, results are unspecified, but `done` still asserts within the latency bound.
- Bounds `lo`, `hi` and midpoint are ADDR_W+1 bits wide so that `hi` can reach −1 and `lo` can reach DEPTH.
  - `mid = (lo + hi) >> 1`, computed at ADDR_W+2 bits.
  - The compare is unsigned `mem[mid]` vs latched key.
- States:
  - IDLE: if `start`, latch `key`, set `lo=0`, `hi=DEPTH-1`, clear `found`/`loc` → PROBE.
  - PROBE: present `mid` as read address → COMPARE.
  - COMPARE (read data valid):
    - equal: `found=1`, `loc=mid[ADDR_W-1:0]` → DONE.
    - `mem<key`: `lo=mid+1`.
    - `mem>key`: `hi=mid-1`.
    - If the updated `lo>hi` (signed compare), `found=0` → DONE; else → PROBE.
  - DONE: `done=1`; outputs held. Stays in DONE while `start` is high; goes to IDLE when `start` is low. A held `start` never retriggers.
- Writes:
  - Accepted only in IDLE or DONE; ignored in PROBE/COMPARE.
  - A write and a `start` accepted in the same IDLE cycle are both honoured, and the write is visible to the first probe.
- Reset (`reset_n` low at an edge):
  - State goes to IDLE. `busy`, `done`, `found`, `loc`, `lb_loc` are all 0. This aborts any search in progress.
  - Memory contents are not cleared.

## Timing
- Memory read latency: exactly 1 cycle (address registered in PROBE, data used in COMPARE).
- With `start` sampled high in IDLE at edge t, after k probes `done` is first high in cycle t+1+2k.
- k ≤ ADDR_W+1, so worst case is t+3+2·ADDR_W (t+13 for ADDR_W=5).
- `busy` is high from t+1 until the cycle before `done`.
- `found`/`loc`/`lb_loc` change only on the accept edge (cleared) and on the COMPARE edge that enters DONE.

## Configuration
- `BSEARCH_LOWER_BOUND_EN` defined:
  - Adds port `lb_loc`, registered on entry to DONE.
  - If found, `lb_loc = {1'b0, loc}`.
  - If not found, `lb_loc` = final `lo`, i.e. the index of the first element > key; it equals DEPTH when every element < key.
  - Reset value 0; cleared on accept.
- Undefined: `lb_loc` port and its logic are absent. All other behaviour is identical.

## Structure
- `bsearch_pkg`:
  - state enum `bs_state_e` {IDLE, PROBE, COMPARE, DONE};
  - helper function for the midpoint width (`ADDR_W+2`).
- Sub-module `bsearch_ram`:
  - DATA_W×DEPTH memory;
  - one write port and one read port with a registered read address (1-cycle latency);
  - no reset;
  - infers block RAM.
- Top `bsearch_engine`: FSM, bound registers, output registers.

## Test plan
Defaults: ADDR_W=5, DATA_W=8. Load `mem[i]=2i` (0..62).
- Load memory; start with key=30 → `done` at t+3, `found=1`, `loc=15`.
- Key=40 → 5 probes (mids 15, 23, 19, 21, 20); `done` at t+11, `found=1`, `loc=20`; `busy` high t+1..t+10.
- Key=41 → `found=0` within t+13; with the macro, `lb_loc=21`. Key=255 → `found=0`, `lb_loc=32`. Key=0 → `found=1`, `loc=0`.
- Hold `start` high after done for 20 cycles → `done` stays high, no new search. Drop `start` → IDLE next cycle; outputs held until the next accept.
- During a key=40 search, pulse `wr_en` with addr 20, data 99 → write ignored, `found=1`, `loc=20`. Repeat the write in IDLE together with `start` → `found=0`.
- Assert `reset_n` low mid-search (cycle t+4) → next cycle all outputs are 0 and state is IDLE. A new key=30 search gives `loc=15`, confirming memory was preserved.
